div_unit: RTL and testbench

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. EX asserts a start request with operands, stalls the pipeline, and waits for `ready_o`. The divider returns a 64-bit `{remainder, quotient}` that EX routes to HI/LO through its existing `hi_o`/`lo_o`/`whilo_o` path. Radix-2 restoring division, one quotient bit per clock.

---
 rtl/div_unit_pkg.sv | 24 ++
 rtl/div_unit.sv | 143 ++++++++++++++
 tb/tb_div_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, FSM state encoding and handshake constants for
// the multi-cycle integer divider, plus a two's-complement negate helper.
package div_unit_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    function automatic logic [REG_BUS-1:0] neg(input logic [REG_BUS-1:0] v);
        return ~v + {{(REG_BUS-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   signed_div_i  1 = signed divide, 0 = unsigned (sampled at start)
//   opdata1_i     dividend (sampled at start)
//   opdata2_i     divisor  (sampled at start)
//   start_i       request from EX, held high until ready_o is seen
//   annul_i       abort an in-flight divide
//   result_o      {remainder, quotient}, valid only while ready_o = 1
//   ready_o       result ready
module div_unit
    import div_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);

    div_state_e                r_state,    w_state_nxt;
    logic [5:0]                r_cnt,      w_cnt_nxt;
    logic [2*REG_BUS:0]        r_dividend, w_dividend_nxt;
    logic [REG_BUS-1:0]        r_divisor,  w_divisor_nxt;
    logic                      r_neg_q,    w_neg_q_nxt;   // quotient must be negated
    logic                      r_neg_r,    w_neg_r_nxt;   // remainder must be negated
    logic [DOUBLE_REG_BUS-1:0] r_result,   w_result_nxt;
    logic                      r_ready,    w_ready_nxt;

    logic [REG_BUS:0]   w_diff;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [REG_BUS-1:0] w_op1_mag;
    logic [REG_BUS-1:0] w_op2_mag;

    // Trial subtract of the divisor from the upper partial remainder; bit 32
    // set means the subtract borrowed and this quotient bit is 0.
    assign w_diff    = {1'b0, r_dividend[2*REG_BUS-1:REG_BUS]} - {1'b0, r_divisor};

    // Sign bits only matter for a signed divide, so unsigned never fixes up.
    assign w_op1_neg = signed_div_i & opdata1_i[REG_BUS-1];
    assign w_op2_neg = signed_div_i & opdata2_i[REG_BUS-1];
    assign w_op1_mag = w_op1_neg ? neg(opdata1_i) : opdata1_i;
    assign w_op2_mag = w_op2_neg ? neg(opdata2_i) : opdata2_i;

    assign result_o  = r_result;
    assign ready_o   = r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= DivFree;
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_result   <= '0;
            r_ready    <= DivResultNotReady;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_neg_q    <= w_neg_q_nxt;
            r_neg_r    <= w_neg_r_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_neg_q_nxt    = r_neg_q;
        w_neg_r_nxt    = r_neg_r;
        w_result_nxt   = r_result;
        w_ready_nxt    = r_ready;

        case (r_state)
            DivFree: begin
                w_ready_nxt  = DivResultNotReady;
                w_result_nxt = '0;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state_nxt = DivByZero;
                    end else begin
                        w_state_nxt    = DivOn;
                        w_cnt_nxt      = '0;
                        w_divisor_nxt  = w_op2_mag;
                        w_neg_q_nxt    = w_op1_neg ^ w_op2_neg;
                        w_neg_r_nxt    = w_op1_neg;
                        // Pre-shifted by one so the first trial subtract sees bit 31.
                        w_dividend_nxt = {{REG_BUS{1'b0}}, w_op1_mag, 1'b0};
                    end
                end
            end

            DivByZero: begin
                w_dividend_nxt = '0;
                w_state_nxt    = DivEnd;
            end

            DivOn: begin
                if (annul_i) begin
                    w_state_nxt = DivFree;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != 6'(REG_BUS)) begin
                    if (w_diff[REG_BUS])
                        w_dividend_nxt = {r_dividend[2*REG_BUS-1:0], 1'b0};
                    else
                        w_dividend_nxt = {w_diff[REG_BUS-1:0], r_dividend[REG_BUS-1:0], 1'b1};
                    w_cnt_nxt = r_cnt + 6'd1;
                end else begin
                    // Quotient sits in [31:0], remainder in [64:33] after the last shift.
                    if (r_neg_q)
                        w_dividend_nxt[REG_BUS-1:0] = neg(r_dividend[REG_BUS-1:0]);
                    if (r_neg_r)
                        w_dividend_nxt[2*REG_BUS:REG_BUS+1] = neg(r_dividend[2*REG_BUS:REG_BUS+1]);
                    w_cnt_nxt   = '0;
                    w_state_nxt = DivEnd;
                end
            end

            DivEnd: begin
                w_ready_nxt  = DivResultReady;
                w_result_nxt = {r_dividend[2*REG_BUS:REG_BUS+1], r_dividend[REG_BUS-1:0]};
                if (start_i == DivStop) begin
                    w_state_nxt  = DivFree;
                    w_ready_nxt  = DivResultNotReady;
                    w_result_nxt = '0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [63:0] res;
        int          edge_no;
        string       name;
    } exp_t;

    exp_t sb[$];

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint dd, dv, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            dd = longint'($signed(a));
            dv = longint'($signed(b));
        end else begin
            dd = longint'({32'd0, a});
            dv = longint'({32'd0, b});
        end
        q = dd / dv;
        r = dd % dv;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: pops on every rising ready_o, checks value and arrival edge,
    // then checks the value is held and that result_o is zero while idle.
    initial begin
        logic        ready_prev;
        logic [63:0] held;
        exp_t        e;
        ready_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ready_o && !ready_prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ready", {63'd0, ready_o}, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_result"}, result_o, e.res);
                        check({e.name, "_edge"}, 64'(cyc), 64'(e.edge_no));
                    end
                    held = result_o;
                end else if (ready_o) begin
                    check("held_result", result_o, held);
                end else begin
                    check("idle_result_zero", result_o, 64'd0);
                end
            end
            ready_prev = ready_o;
        end
    end

    // Issues one divide at a negedge and returns at a negedge with the unit idle.
    task automatic run_div(input string name, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int hold, input bit annul_in_end);
        exp_t e;
        int   n;
        e.name    = name;
        e.res     = exp;
        e.edge_no = cyc + 1 + ((b == 32'd0) ? 2 : 34);
        sb.push_back(e);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(negedge clk);
        // Operands must have been captured at start; scramble them now.
        signed_div_i = 1'($urandom_range(0, 1));
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        n = 1;
        while (!ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            check({name, "_timeout"}, {63'd0, ready_o}, 64'd1);
            sb.delete();
            start_i = 1'b0;
            @(negedge clk);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            annul_i = annul_in_end;
            @(negedge clk);
            check({name, "_ready_hold"}, {63'd0, ready_o}, 64'd1);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check({name, "_ready_drop"}, {63'd0, ready_o}, 64'd0);
    endtask

    initial begin
        exp_t        e;
        bit          s;
        logic [31:0] a, b;
        int          n;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #1;
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_div("u100_7",   0, 32'd100, 32'd7, {32'h2, 32'hE}, 2, 0);
        run_div("s-7_2",    1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 0);
        run_div("s7_-2",    1, 32'd7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 1, 0);
        run_div("u_div0",   0, 32'd5, 32'd0, 64'd0, 1, 0);
        run_div("s_div0",   1, 32'hFFFFFFFB, 32'd0, 64'd0, 0, 0);
        run_div("s_ovf",    1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 0, 0);
        run_div("u_ovf",    0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 0, 0);
        run_div("annul_end",0, 32'd100, 32'd7, {32'h2, 32'hE}, 3, 1);

        // Annul at E10 kills the divide; a new request follows straight away.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        check("annul_no_ready", {63'd0, ready_o}, 64'd0);
        run_div("after_annul_9_3", 0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, 0);

        // Annul held in idle must block acceptance.
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (5) @(negedge clk);
        annul_i = 1'b0;
        run_div("blocked_then_50_5", 0, 32'd50, 32'd5, {32'd0, 32'd10}, 0, 0);

        // Async reset mid-iteration.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_divon_ready", {63'd0, ready_o}, 64'd0);
        check("rst_divon_result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b0;
        @(negedge clk);
        run_div("after_rst_1000_7", 0, 32'd1000, 32'd7, {32'd6, 32'd142}, 0, 0);

        // Async reset while a result is being held: outputs clear with no edge.
        e.name    = "pre_rst_77_5";
        e.res     = {32'd2, 32'd15};
        e.edge_no = cyc + 1 + 34;
        sb.push_back(e);
        opdata1_i = 32'd77;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        n = 0;
        while (!ready_o && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_ready", {63'd0, ready_o}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_end_ready", {63'd0, ready_o}, 64'd0);
        check("rst_end_result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b0;
        sb.delete();
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            n = $urandom_range(0, 9);
            if (n == 0)      b = 32'd0;
            else if (n < 4)  b = 32'($urandom_range(1, 20));
            else if (n < 6)  b = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
            else             b = $urandom;
            if (n == 9) a = 32'($urandom_range(0, 100));
            run_div($sformatf("rand%0d", i), s, a, b, model(s, a, b), $urandom_range(0, 3), 0);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
